// File: rtl/jp_scanner_if.sv
// Pin- and result-side bundle of the joypad scanner.
// master = scanner, slave = pads plus the result consumer.
interface jp_scanner_if #(
  parameter int NUM_PORTS = 2,
  parameter int NUM_BITS  = 8
);
  logic                          poll_req;
  logic [NUM_PORTS-1:0]          jp_data_in;
  logic                          jp_latch_out;
  logic [NUM_PORTS-1:0]          jp_clk_out;
  logic [NUM_PORTS*NUM_BITS-1:0] buttons_out;
  logic [NUM_PORTS-1:0]          connected_out;
  logic                          valid_out;
  logic                          busy_out;

  modport master (
    input  poll_req, jp_data_in,
    output jp_latch_out, jp_clk_out, buttons_out, connected_out, valid_out, busy_out
  );
  modport slave (
    output poll_req, jp_data_in,
    input  jp_latch_out, jp_clk_out, buttons_out, connected_out, valid_out, busy_out
  );
endinterface

// File: rtl/jp_scanner.sv
// N-port serial joypad scanner: shared latch, per-port shift clocks,
// 2-flop data sync, signature-based connect detection, optional auto-poll.
module jp_scanner_lane #(
  parameter int NUM_BITS = 8,
  parameter int SIG_BITS = 1,
  parameter int IDX_W    = 4
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                data_raw,
  input  logic                sample_en,
  input  logic                publish,
  input  logic [IDX_W-1:0]    idx,
  output logic                connected,
  output logic [NUM_BITS-1:0] buttons
);
  localparam int TOT = NUM_BITS + SIG_BITS;

  logic [1:0]     sync;
  logic [TOT-1:0] samples;
  logic           det;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sync      <= '1;
      samples   <= '0;
      connected <= 1'b0;
      buttons   <= '0;
    end else begin
      sync <= {sync[0], data_raw};
      for (int b = 0; b < TOT; b++)
        if (sample_en && idx == b[IDX_W-1:0]) samples[b] <= sync[1];
      // pads drive low for pressed; a missing pad never reports presses
      if (publish) begin
        connected <= det;
        buttons   <= det ? ~samples[NUM_BITS-1:0] : '0;
      end
    end
  end

  if (SIG_BITS > 0) begin : g_sig
    assign det = &samples[TOT-1:NUM_BITS];
  end else begin : g_any
    assign det = |samples[NUM_BITS-1:0];
  end
endmodule

module jp_scanner #(
  parameter int NUM_PORTS   = 2,
  parameter int NUM_BITS    = 8,
  parameter int SIG_BITS    = 1,
  parameter int HALF_PERIOD = 6,
  parameter int AUTO_POLL   = 0,
  parameter int POLL_PERIOD = 416667
) (
  input logic        clk_in,
  input logic        rst_n,
  jp_scanner_if.master bus
);
  localparam int TOT   = NUM_BITS + SIG_BITS;
  localparam int IDX_W = (TOT > 1) ? $clog2(TOT) : 1;
  localparam int CNT_W = $clog2(2 * HALF_PERIOD);
  localparam int PW    = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(TOT - 1);

  typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

  state_t                            state, state_nx;
  logic [CNT_W-1:0]                  cnt, cnt_nx;
  logic [IDX_W-1:0]                  idx, idx_nx;
  logic                              sample_en, publish, auto_trig;
  logic [NUM_PORTS-1:0][NUM_BITS-1:0] btn;
  logic [NUM_PORTS-1:0]              conn;

  if (AUTO_POLL != 0) begin : g_auto
    logic [PW-1:0] poll_cnt;
    always_ff @(posedge clk_in) begin
      if (!rst_n || poll_cnt == PW'(POLL_PERIOD - 1)) poll_cnt <= '0;
      else                                             poll_cnt <= poll_cnt + 1'b1;
    end
    assign auto_trig = (poll_cnt == PW'(POLL_PERIOD - 1));
  end else begin : g_manual
    assign auto_trig = 1'b0;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    idx_nx    = idx;
    sample_en = 1'b0;
    publish   = 1'b0;
    case (state)
      IDLE:
        if (bus.poll_req || auto_trig) begin
          state_nx = LATCH;
          cnt_nx   = '0;
        end
      LATCH:
        if (cnt == LATCH_LAST) begin
          state_nx = LOW;
          cnt_nx   = '0;
          idx_nx   = '0;
        end else cnt_nx = cnt + 1'b1;
      LOW:
        if (cnt == HALF_LAST) begin
          sample_en = 1'b1;
          state_nx  = HIGH;
          cnt_nx    = '0;
        end else cnt_nx = cnt + 1'b1;
      // results are registered on entry to DONE so they line up with valid_out
      HIGH:
        if (cnt == HALF_LAST) begin
          cnt_nx = '0;
          if (idx == IDX_LAST) begin
            state_nx = DONE;
            publish  = 1'b1;
          end else begin
            idx_nx   = idx + 1'b1;
            state_nx = LOW;
          end
        end else cnt_nx = cnt + 1'b1;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
    jp_scanner_lane #(.NUM_BITS(NUM_BITS), .SIG_BITS(SIG_BITS), .IDX_W(IDX_W)) u_lane (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .data_raw  (bus.jp_data_in[p]),
      .sample_en (sample_en),
      .publish   (publish),
      .idx       (idx),
      .connected (conn[p]),
      .buttons   (btn[p])
    );
  end

  assign bus.jp_latch_out  = (state == LATCH);
  assign bus.jp_clk_out    = {NUM_PORTS{state != LOW}};
  assign bus.valid_out     = (state == DONE);
  assign bus.busy_out      = (state != IDLE);
  assign bus.buttons_out   = btn;
  assign bus.connected_out = conn;
endmodule

// File: tb/tb_jp_scanner.sv
// Randomized bench for jp_scanner: behavioural pad + expected-result model,
// one manual-poll instance and one auto-poll instance.
module tb_jp_scanner;
  localparam int NP  = 2;
  localparam int NB  = 8;
  localparam int SB  = 1;
  localparam int H   = 4;
  localparam int TOT = NB + SB;
  localparam int SCAN_LEN = 2*H + TOT*2*H + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n;
  int   n_run = 0, n_fail = 0;

  jp_scanner_if #(.NUM_PORTS(NP), .NUM_BITS(NB)) a_if();
  jp_scanner_if #(.NUM_PORTS(NP), .NUM_BITS(NB)) b_if();

  jp_scanner #(.NUM_PORTS(NP), .NUM_BITS(NB), .SIG_BITS(SB), .HALF_PERIOD(H),
               .AUTO_POLL(0), .POLL_PERIOD(100)) dut_a (
    .clk_in(clk), .rst_n(rst_a_n), .bus(a_if.master));
  jp_scanner #(.NUM_PORTS(NP), .NUM_BITS(NB), .SIG_BITS(SB), .HALF_PERIOD(H),
               .AUTO_POLL(1), .POLL_PERIOD(100)) dut_b (
    .clk_in(clk), .rst_n(rst_b_n), .bus(b_if.master));

  // pad model: report loads while latch is high, shifts on each jp_clk rise, 1s fill behind
  logic [NP-1:0][TOT-1:0] rpt_a, rpt_b;
  logic [NP-1:0]          pres_a, pres_b;
  logic [NP-1:0][15:0]    sr_a = '1, sr_b = '1;
  logic [NP-1:0]          pclk_a = '1, pclk_b = '1;

  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (a_if.jp_latch_out) sr_a[p] <= {{(16-TOT){1'b1}}, rpt_a[p]};
      else if (a_if.jp_clk_out[p] && !pclk_a[p]) sr_a[p] <= {1'b1, sr_a[p][15:1]};
      if (b_if.jp_latch_out) sr_b[p] <= {{(16-TOT){1'b1}}, rpt_b[p]};
      else if (b_if.jp_clk_out[p] && !pclk_b[p]) sr_b[p] <= {1'b1, sr_b[p][15:1]};
    end
    pclk_a <= a_if.jp_clk_out;
    pclk_b <= b_if.jp_clk_out;
  end

  always_comb begin
    a_if.jp_data_in = '0;
    b_if.jp_data_in = '0;
    for (int p = 0; p < NP; p++) begin
      a_if.jp_data_in[p] = pres_a[p] & sr_a[p][0];
      b_if.jp_data_in[p] = pres_b[p] & sr_b[p][0];
    end
  end
  assign b_if.poll_req = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected results straight from the line pattern: first-shifted bit = LSB
  function automatic logic [NP*NB-1:0] exp_btn(input logic [NP-1:0][TOT-1:0] r, input logic [NP-1:0] pres);
    logic [NP*NB-1:0] w = '0;
    for (int p = 0; p < NP; p++) begin
      int ones = 0;
      for (int s = NB; s < TOT; s++) ones += (pres[p] & r[p][s]) ? 1 : 0;
      if (ones == SB)
        for (int b = 0; b < NB; b++) w[p*NB + b] = ~r[p][b];
    end
    return w;
  endfunction

  function automatic logic [NP-1:0] exp_conn(input logic [NP-1:0][TOT-1:0] r, input logic [NP-1:0] pres);
    logic [NP-1:0] c = '0;
    for (int p = 0; p < NP; p++) begin
      int ones = 0;
      for (int s = NB; s < TOT; s++) ones += (pres[p] & r[p][s]) ? 1 : 0;
      c[p] = (ones == SB);
    end
    return c;
  endfunction

  task automatic scan_a(input string tag, input int extra_req, input int rst_at);
    int lat_n = 0, lat_first = -1, vcnt = 0, vcyc = -1, busy_n = 0;
    int rises [NP];
    logic [NP-1:0]    prev;
    logic [NP*NB-1:0] btn_v = '0;
    logic [NP-1:0]    conn_v = '0;
    for (int p = 0; p < NP; p++) rises[p] = 0;
    prev = a_if.jp_clk_out;
    a_if.poll_req = 1'b1;
    tick();
    a_if.poll_req = 1'b0;
    for (int c = 1; c <= SCAN_LEN + 40; c++) begin
      if (a_if.jp_latch_out) begin
        lat_n++;
        if (lat_first < 0) lat_first = c;
      end
      for (int p = 0; p < NP; p++) if (a_if.jp_clk_out[p] && !prev[p]) rises[p]++;
      prev = a_if.jp_clk_out;
      if (a_if.busy_out) busy_n++;
      if (a_if.valid_out) begin
        vcnt++;
        vcyc   = c;
        btn_v  = a_if.buttons_out;
        conn_v = a_if.connected_out;
      end
      if (rst_at >= 0 && c == rst_at + 1) begin
        chk({tag, "_abort_state"},
            {a_if.jp_latch_out, a_if.jp_clk_out, a_if.buttons_out, a_if.connected_out,
             a_if.valid_out, a_if.busy_out},
            {1'b0, 2'b11, 16'h0, 2'b00, 1'b0, 1'b0});
        rst_a_n = 1'b1;
      end
      a_if.poll_req = (c == extra_req);
      if (c == rst_at) rst_a_n = 1'b0;
      tick();
    end
    if (rst_at >= 0) begin
      chk({tag, "_no_valid"}, vcnt, 0);
    end else begin
      chk({tag, "_latch_first"}, lat_first, 1);
      chk({tag, "_latch_len"}, lat_n, 2*H);
      for (int p = 0; p < NP; p++) chk({tag, "_clk_pulses"}, rises[p], TOT);
      chk({tag, "_valid_cnt"}, vcnt, 1);
      chk({tag, "_valid_cyc"}, vcyc, SCAN_LEN);
      chk({tag, "_busy_len"}, busy_n, SCAN_LEN);
      chk({tag, "_buttons"}, btn_v, exp_btn(rpt_a, pres_a));
      chk({tag, "_connected"}, conn_v, exp_conn(rpt_a, pres_a));
      chk({tag, "_hold"}, a_if.buttons_out, exp_btn(rpt_a, pres_a));
    end
  endtask

  initial begin
    int vt [3];
    int k, t;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    a_if.poll_req = 1'b0;
    rpt_a  = {9'h1FF, 9'h1F6};
    pres_a = 2'b11;
    rpt_b  = {9'h1FF, 9'h1F6};
    pres_b = 2'b11;

    repeat (3) tick();
    rst_a_n = 1'b1;
    tick();
    chk("rst_latch", a_if.jp_latch_out, 0);
    chk("rst_clk", a_if.jp_clk_out, 2'b11);
    chk("rst_buttons", a_if.buttons_out, 0);
    chk("rst_connected", a_if.connected_out, 0);
    chk("rst_busy", a_if.busy_out, 0);
    chk("rst_valid", a_if.valid_out, 0);

    scan_a("basic", -1, -1);
    chk("basic_literal", a_if.buttons_out, 16'h0009);

    pres_a = 2'b01;
    scan_a("missing", -1, -1);

    rpt_a  = {9'h1FF, 9'h100};
    pres_a = 2'b11;
    scan_a("all_pressed", -1, -1);

    rpt_a = {9'h1FF, 9'h1F6};
    scan_a("busy_drop", 20, -1);
    scan_a("abort", -1, 40);

    for (int i = 0; i < 6; i++) begin
      for (int p = 0; p < NP; p++) begin
        rpt_a[p] = {($urandom_range(0, 3) != 0), 8'($urandom)};
        pres_a[p] = ($urandom_range(0, 4) != 0);
      end
      scan_a("rand", -1, -1);
    end

    rst_b_n = 1'b1;
    k = 0;
    t = 0;
    while (k < 3 && t < 400) begin
      if (b_if.valid_out) begin
        chk("auto_buttons", b_if.buttons_out, exp_btn(rpt_b, pres_b));
        chk("auto_connected", b_if.connected_out, exp_conn(rpt_b, pres_b));
        vt[k] = t;
        k++;
        rpt_b[0] = {1'b1, 8'($urandom)};
        rpt_b[1] = {1'b1, 8'($urandom)};
      end
      tick();
      t++;
    end
    chk("auto_scan_count", k, 3);
    if (k == 3) begin
      chk("auto_period_1", vt[1] - vt[0], 100);
      chk("auto_period_2", vt[2] - vt[1], 100);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/jp_scanner.md
Name: jp_scanner

Overview:
- Parametrised multi-port serial game-controller scanner. Generalises the fixed two-port joypad sync/disable logic to N ports, configurable report length, signature-based connect/disconnect detection, and optional autonomous polling.
- Drives the shared latch and per-port clocks, synchronises the data lines, and publishes active-high button words with a one-cycle valid strobe.
- Sits between the joypad pins and the CPU-side controller registers, or feeds a debug/overlay consumer directly.

Parameters:
- NUM_PORTS, 2: number of controller ports.
- NUM_BITS, 8: button bits per report. Use 8 for NES pads, 12/16 for SNES-style pads.
- SIG_BITS, 1: extra clock pulses after the button bits; a connected pad returns 1 on these.
- HALF_PERIOD, 6: system clocks per half bit-period. Must be >= 4.
- AUTO_POLL, 0: 1 = internal periodic trigger, 0 = poll_req only.
- POLL_PERIOD, 416667: clocks between auto-poll triggers. Must be >= scan length.

Ports:
- clk_in  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- poll_req  input  1  single-cycle scan request; ignored while busy.
- jp_data_in  input  NUM_PORTS  raw serial data, one per port, asynchronous.
- jp_latch_out  output  1  shared latch, active high. The board inverts it externally if needed.
- jp_clk_out  output  NUM_PORTS  per-port shift clocks. Idle high; all ports driven identically.
- buttons_out  output  NUM_PORTS*NUM_BITS  pressed = 1. Port p occupies bits [p*NUM_BITS +: NUM_BITS]; first-shifted bit is LSB.
- connected_out  output  NUM_PORTS  port detected in last completed scan.
- valid_out  output  1  one-cycle pulse when buttons_out/connected_out update.
- busy_out  output  1  scan in progress.

Behaviour:
- Reset and clocking: one clock, clk_in. Reset is synchronous, active-low on rst_n; all state updates only on clk_in rising edge.
- Reset values: jp_latch_out=0, jp_clk_out=all 1, buttons_out=0, connected_out=0, valid_out=0, busy_out=0, FSM=IDLE, all counters 0, synchroniser flops 1.
- Reset taken mid-scan aborts the scan at the next edge with the same values. No partial results are published.
- Synchroniser: 2-flop per data line. Every sample point uses the second flop.
- Trigger: in IDLE, a trigger is poll_req=1, or, when AUTO_POLL=1, the free-running poll counter reaching POLL_PERIOD-1. On a trigger, go to LATCH at the next edge.
  - The poll counter is free-running and wraps to 0 on reaching POLL_PERIOD-1.
  - A trigger not in IDLE is dropped, not queued. Simultaneous poll_req and auto trigger give one scan.
- FSM states:
  - IDLE: outputs idle; busy_out=0.
  - LATCH: jp_latch_out=1 for 2*HALF_PERIOD cycles, then go to LOW with bit index 0.
  - LOW: jp_clk_out=0 for HALF_PERIOD cycles. On the last LOW cycle, sample every port's synchronised data into bit[index].
  - HIGH: jp_clk_out=1 for HALF_PERIOD cycles; the rising edge shifts the pad. At the end, if index = NUM_BITS+SIG_BITS-1 go to DONE, else index+1 and go to LOW.
  - DONE: one cycle. Publish results, valid_out=1, then IDLE.
- busy_out=1 in LATCH/LOW/HIGH/DONE.
- Scan length from LATCH entry to the DONE cycle inclusive: 2H + (NUM_BITS+SIG_BITS)*2H + 1 cycles, H=HALF_PERIOD.
- Detection at DONE, per port:
  - SIG_BITS>0: connected = all SIG_BITS samples equal 1.
  - SIG_BITS=0: connected = at least one of the NUM_BITS samples equals 1.
- Publish at DONE:
  - buttons_out word = connected ? ~samples[NUM_BITS-1:0] : 0. A floating or missing pad never reports presses.
  - connected_out updated every scan; a port can connect and disconnect scan-to-scan.
- buttons_out and connected_out hold between DONE cycles. valid_out is high for exactly one cycle per completed scan.

Test Plan:
Bench config: NUM_PORTS=2, NUM_BITS=8, SIG_BITS=1, HALF_PERIOD=4, AUTO_POLL=0. Pad model loads its report on the latch and shifts on the jp_clk rising edge. poll_req pulses at cycle 0.
1. Reset and idle: hold rst_n=0 for 3 cycles, then release. Required: jp_latch_out=0, jp_clk_out=2'b11, buttons_out=0, connected_out=0, busy_out=0, valid_out=0.
2. Basic scan: port0 presses A and Start (line pattern 0,1,1,0,1,1,1,1 then 1); port1 presses nothing (all 1). Required:
   - latch high cycles 1-8; 9 clock pulses per port.
   - valid_out at cycle 81.
   - buttons_out=16'h0009; connected_out=2'b11.
3. Missing pad: port1 data tied 0. Required: connected_out[1]=0 and buttons_out[15:8]=0. Port0 unaffected.
4. All buttons pressed on port0 (8 zeros then signature 1). Required: connected_out[0]=1, buttons_out[7:0]=8'hFF.
5. Busy drop and abort:
   - poll_req at cycle 20: required no second scan; exactly one valid_out.
   - Separately, rst_n=0 at cycle 40: required outputs at reset values the next cycle and no valid_out.
6. AUTO_POLL=1, POLL_PERIOD=100, no poll_req. Required: valid_out pulses exactly 100 cycles apart and results track a pad pattern change between scans.
